// File: rtl/vec_collect.sv
// vec_collect: serial-to-parallel front end for the argmax tree.
// Packs NEl samples per frame, pads short frames with PAD.
module vec_collect #(
  parameter int NEl  = 8,
  parameter int BWID = 16,
  parameter logic [BWID-1:0] PAD = '0,
  localparam int IW = $clog2(NEl) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BWID-1:0]   iData,
  input  logic              iValid,
  input  logic              iLast,
  output logic [BWID*NEl-1:0] oVData,
  output logic [IW*NEl-1:0] oVIndx,
  output logic              oND,
  output logic [IW-1:0]     oCnt,
  output logic              oShort
);

  localparam logic [IW-1:0] LAST = IW'(NEl - 1);

  logic [BWID-1:0]     shd [NEl];
  logic [IW-1:0]       wp;
  logic                close;
  logic [BWID*NEl-1:0] nv;

  assign close = iValid && (wp == LAST || iLast);

  // constant slot indices for the tree
  for (genvar k = 0; k < NEl; k++) begin : g_idx
    assign oVIndx[IW*k +: IW] = IW'(k);
  end

  // shadow buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (iValid)
      shd[wp] <= iData;
  end

  // next frame: shadow below wp, bypassed sample at wp, PAD above
  always_comb begin
    nv = '0;
    for (int k = 0; k < NEl; k++) begin
      if (k < int'(wp))
        nv[k*BWID +: BWID] = shd[k];
      else if (k == int'(wp))
        nv[k*BWID +: BWID] = iData;
      else
        nv[k*BWID +: BWID] = PAD;
    end
  end

  // write pointer: advance on valid, wrap to slot 0 on close
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wp <= '0;
    else if (close)
      wp <= '0;
    else if (iValid)
      wp <= wp + IW'(1);
  end

  // frame outputs: updated on close, held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oVData <= '0;
      oND    <= 1'b0;
      oCnt   <= '0;
      oShort <= 1'b0;
    end else begin
      oND <= close;
      if (close) begin
        oVData <= nv;
        oCnt   <= wp + IW'(1);
        oShort <= (wp != LAST);
      end
    end
  end

endmodule
